// File: rtl/demux_8x1_seq_pkg.sv
// demux_8x1_seq_pkg: shared FSM state type, sizes and mode encodings
package demux_8x1_seq_pkg;
  localparam int NUM_CH = 8;
  localparam int SEL_W = 3;
  localparam logic MODE_ADDR = 1'b0;
  localparam logic MODE_AUTO = 1'b1;
  typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;
endpackage

// File: rtl/demux_1x8_dec.sv
// demux_1x8_dec: one-hot decode of a 3-bit write index into per-bit write strobes
// en_i: write enable; idx_i: bit index; strobe_o: one-hot strobe (all zero when disabled)
module demux_1x8_dec
  import demux_8x1_seq_pkg::*;
(
  input  logic             en_i,
  input  logic [SEL_W-1:0] idx_i,
  output logic [NUM_CH-1:0] strobe_o
);
  always_comb strobe_o = en_i ? NUM_CH'(1) << idx_i : '0;
endmodule

// File: rtl/demux_8x1_seq.sv
// demux_8x1_seq: serial 1-to-8 demultiplexer with addressed mode and auto frame assembly
// clk/rst: clock, async active-high reset; d/in_valid/in_ready: serial input handshake
// s: addressed-mode select; mode: 0 addressed, 1 auto; y: registered outputs
// out_valid/out_ready: completed-frame handshake (auto mode)
// DEMUX_PARITY_EN: auto frames take a ninth even-parity bit and expose parity_err
module demux_8x1_seq
  import demux_8x1_seq_pkg::*;
#(
  parameter logic CLR_VAL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             d,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SEL_W-1:0] s,
  input  logic             mode,
  output logic [NUM_CH-1:0] y,
  output logic             out_valid,
`ifdef DEMUX_PARITY_EN
  output logic             parity_err,
`endif
  input  logic             out_ready
);
  state_t state_q, state_d;
  logic [SEL_W-1:0] cnt_q, cnt_d;
  logic [NUM_CH-1:0] y_q, y_d, wr;
  logic xfer, clr, wr_en, last;
`ifdef DEMUX_PARITY_EN
  logic par_q, par_d, err_q, err_d;
`endif
  assign in_ready = (mode == MODE_ADDR) | (state_q != HOLD);
  assign xfer = in_valid & in_ready;
  assign last = cnt_q == SEL_W'(NUM_CH - 1);
`ifdef DEMUX_PARITY_EN
  // the parity bit is consumed without touching y
  assign wr_en = xfer & ~((mode == MODE_AUTO) & par_q);
`else
  assign wr_en = xfer;
`endif
  // cnt is 0 in IDLE, so it doubles as the frame-start index
  demux_1x8_dec u_dec (
    .en_i    (wr_en),
    .idx_i   ((mode == MODE_ADDR) ? s : cnt_q),
    .strobe_o(wr)
  );
  always_comb y_d = ((clr ? {NUM_CH{CLR_VAL}} : y_q) & ~wr) | ({NUM_CH{d}} & wr);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    clr = 1'b0;
`ifdef DEMUX_PARITY_EN
    par_d = par_q;
    err_d = err_q;
`endif
    if (mode == MODE_ADDR) begin
      state_d = IDLE;
      cnt_d = '0;
`ifdef DEMUX_PARITY_EN
      par_d = 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: if (xfer) begin
          clr = 1'b1;
          cnt_d = SEL_W'(1);
          state_d = COLLECT;
        end
        COLLECT: if (xfer) begin
`ifdef DEMUX_PARITY_EN
          if (par_q) begin
            err_d = d ^ (^y_q);
            par_d = 1'b0;
            state_d = HOLD;
          end else begin
            cnt_d = cnt_q + SEL_W'(1);
            par_d = last;
          end
`else
          cnt_d = cnt_q + SEL_W'(1);
          state_d = last ? HOLD : COLLECT;
`endif
        end
        HOLD: state_d = out_ready ? IDLE : HOLD;
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      y_q <= {NUM_CH{CLR_VAL}};
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      y_q <= y_d;
    end
  end
`ifdef DEMUX_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      par_q <= par_d;
      err_q <= err_d;
    end
  end
  assign parity_err = err_q;
`endif
  assign y = y_q;
  assign out_valid = state_q == HOLD;
endmodule

// File: tb/tb_demux_8x1_seq.sv
// tb_demux_8x1_seq: directed self-checking bench for demux_8x1_seq
module tb_demux_8x1_seq;
  logic clk = 1'b0, rst = 1'b1, d = 1'b0, in_valid = 1'b0, mode = 1'b0, out_ready = 1'b0;
  logic [2:0] s = '0;
  logic in_ready, out_valid;
  logic [7:0] y;
`ifdef DEMUX_PARITY_EN
  logic parity_err;
`endif
  int vectors = 0, miscompares = 0, ov_rises = 0;
  always #5 clk = ~clk;
  always @(posedge out_valid) ov_rises++;
  demux_8x1_seq dut (
    .clk(clk), .rst(rst), .d(d), .in_valid(in_valid), .in_ready(in_ready),
    .s(s), .mode(mode), .y(y), .out_valid(out_valid),
`ifdef DEMUX_PARITY_EN
    .parity_err(parity_err),
`endif
    .out_ready(out_ready)
  );
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic b, input logic [2:0] sel);
    d = b;
    s = sel;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask
  task automatic stream(input logic [7:0] v, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      send(v[i], 3'd0);
      if (i < n - 1) repeat (gap) tick();
    end
  endtask
  task automatic release_frame;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask
  initial begin
    repeat (2) tick();
    chk("rst_y", y, 8'h00);
    chk("rst_ov", {7'd0, out_valid}, 8'h00);
    chk("rst_ir", {7'd0, in_ready}, 8'h01);
    rst = 1'b0;
    tick();
    // addressed writes
    mode = 1'b0;
    send(1'b1, 3'd3);
    chk("addr_s3", y, 8'h08);
    send(1'b1, 3'd5);
    chk("addr_s5", y, 8'h28);
    chk("addr_ov", {7'd0, out_valid}, 8'h00);
    chk("addr_ir", {7'd0, in_ready}, 8'h01);
    // auto, back to back: frame start clears the old 0x28
    mode = 1'b1;
    stream(8'h4D, 7, 0);
    chk("auto7_y", y, 8'h4D);
    chk("auto7_ov", {7'd0, out_valid}, 8'h00);
`ifdef DEMUX_PARITY_EN
    send(1'b0, 3'd0);
    chk("auto8_ov_par", {7'd0, out_valid}, 8'h00);
    send(1'b0, 3'd0);
    chk("par0_err", {7'd0, parity_err}, 8'h00);
`else
    send(1'b0, 3'd0);
`endif
    chk("auto8_y", y, 8'h4D);
    chk("auto8_ov", {7'd0, out_valid}, 8'h01);
    chk("auto8_ir", {7'd0, in_ready}, 8'h00);
    // HOLD ignores input while out_ready is low
    d = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_y", y, 8'h4D);
      chk("hold_ov", {7'd0, out_valid}, 8'h01);
    end
    in_valid = 1'b0;
    release_frame();
    chk("rel_ov", {7'd0, out_valid}, 8'h00);
    chk("rel_ir", {7'd0, in_ready}, 8'h01);
    // auto with 2-cycle gaps
    stream(8'h4D, 7, 2);
    repeat (2) tick();
    chk("gap7_ov", {7'd0, out_valid}, 8'h00);
`ifdef DEMUX_PARITY_EN
    send(1'b0, 3'd0);
    repeat (2) tick();
    send(1'b1, 3'd0);
    chk("par1_err", {7'd0, parity_err}, 8'h01);
`else
    send(1'b0, 3'd0);
`endif
    chk("gap_y", y, 8'h4D);
    chk("gap_ov", {7'd0, out_valid}, 8'h01);
    release_frame();
    // asynchronous reset mid-frame
    stream(8'h0D, 4, 0);
    chk("mid4_y", y, 8'h0D);
    #2 rst = 1'b1;
    #1;
    chk("arst_y", y, 8'h00);
    chk("arst_ov", {7'd0, out_valid}, 8'h00);
    tick();
    rst = 1'b0;
    repeat (2) tick();
    chk("post_rst_ov", {7'd0, out_valid}, 8'h00);
    stream(8'hFF, 8, 0);
`ifdef DEMUX_PARITY_EN
    send(1'b0, 3'd0);
`endif
    chk("ff_y", y, 8'hFF);
    chk("ff_ov", {7'd0, out_valid}, 8'h01);
    release_frame();
    // mode switch mid-frame
    stream(8'h1F, 5, 0);
    chk("sw5_y", y, 8'h1F);
    mode = 1'b0;
    tick();
    chk("sw_ov", {7'd0, out_valid}, 8'h00);
    chk("sw_ir", {7'd0, in_ready}, 8'h01);
    send(1'b1, 3'd7);
    chk("sw_s7", y, 8'h9F);
    // back in auto, the FSM must be in IDLE: next bit clears y and lands in y[0]
    mode = 1'b1;
    send(1'b0, 3'd0);
    chk("sw_idle_y", y, 8'h00);
    mode = 1'b0;
    tick();
    chk("sw_idle_ov", {7'd0, out_valid}, 8'h00);
`ifdef DEMUX_PARITY_EN
    chk("ov_rises", 8'(ov_rises), 8'd3);
`else
    chk("ov_rises", 8'(ov_rises), 8'd3);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/demux_8x1_seq.md
DEMUX_8X1_SEQ -- requirements
Module: demux_8x1_seq

Interface
REQ-001 Parameter: CLR_VAL, 1'b0, value loaded into every y bit on reset and on frame start in auto mode.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 d  input  1  serial data bit to route.
REQ-005 in_valid  input  1  d (and s in addressed mode) valid this cycle.
REQ-006 in_ready  output  1  block can accept d this cycle.
REQ-007 s  input  3  destination select in addressed mode: 3'b000 -> y[0] ... 3'b111 -> y[7].
REQ-008 mode  input  1  0 = addressed, 1 = auto-sequence (frame assembly).
REQ-009 y  output  8  registered demultiplexed outputs.
REQ-010 out_valid  output  1  auto mode: y holds a complete 8-bit frame.
REQ-011 out_ready  input  1  consumer accepts the frame.

Function
REQ-012 Input transfer occurs only on a cycle with in_valid=1 and in_ready=1.
REQ-013 Addressed mode: in_ready is constantly 1; each transfer writes y[s] <= d on the next edge; the other seven bits hold; out_valid stays 0.
REQ-014 Auto mode uses an FSM with states IDLE, COLLECT, HOLD and a 3-bit counter cnt.
REQ-015 IDLE: in_ready=1; on a transfer, load y to all CLR_VAL, then write y[0] <= d, set cnt=1, go to COLLECT.
REQ-016 COLLECT: in_ready=1; each transfer writes y[cnt] <= d and increments cnt; the transfer with cnt=7 wraps cnt to 0 and enters HOLD.
REQ-017 HOLD: out_valid=1 and in_ready=0; y is frozen; on out_ready=1, go to IDLE next cycle with out_valid=0.
REQ-018 Latency: out_valid rises on the edge that captures the eighth bit; bit k of the frame lands in y[k] (LSB first).
REQ-019 Cycles with in_valid=0 in COLLECT hold cnt and y; gaps do not abort the frame.
REQ-020 A mode change while in COLLECT or HOLD returns the FSM to IDLE, clears cnt, and drops out_valid; y is not cleared.
REQ-021 A mode change is sampled before the transfer rule, so the transfer on the change cycle follows the new mode.
REQ-022 The s input is ignored in auto mode; mode, s and d are don't-care when in_valid=0.

Reset
REQ-023 While rst=1: y = {8{CLR_VAL}}, out_valid=0, cnt=0, FSM=IDLE; in_ready follows REQ-013/REQ-015 (it is 1).
REQ-024 Reset asserted mid-frame discards the partial frame; no out_valid pulse follows the deassertion.

Configuration
REQ-025 With macro DEMUX_PARITY_EN defined, auto mode collects a ninth bit (even parity over y[7:0]) after y[7]. HOLD is entered after the ninth bit, and a 1-bit output parity_err is valid with out_valid (1 = parity mismatch).
REQ-026 Without DEMUX_PARITY_EN, frames are 8 bits, the parity_err port does not exist, and no parity logic is built.

Structure
REQ-027 A shared package holds the FSM state typedef (IDLE, COLLECT, HOLD), the constants NUM_CH=8 and SEL_W=3, and the mode encodings.
REQ-028 One sub-module, demux_1x8_dec, is built: combinational 3-to-8 one-hot decode of the write index, gated by the write enable. It is used in both modes to form the per-bit write strobes.

Verification
REQ-029 Addressed mode: transfers s=3,d=1 then s=5,d=1 -> y=8'b0010_1000 after the second edge; out_valid never asserts.
REQ-030 Auto mode, back-to-back: stream 1,0,1,1,0,0,1,0 -> y=8'h4D with out_valid=1 on the eighth edge and in_ready=0. Hold out_ready=0 for 3 cycles -> y stable. Then pulse out_ready -> IDLE.
REQ-031 Auto mode, in_valid gaps of 2 cycles between bits -> same y=8'h4D; out_valid is asserted exactly once.
REQ-032 Apply rst after 4 bits of a frame -> y=8'h00 (CLR_VAL=0) and out_valid=0. A fresh 8-bit stream 8'hFF then gives y=8'hFF.
REQ-033 Switch mode 1->0 after 5 bits -> FSM returns to IDLE and out_valid stays 0. The next addressed write s=7,d=1 sets y[7].
REQ-034 With DEMUX_PARITY_EN: 8'h4D plus parity bit 0 -> parity_err=0; the same stream with parity bit 1 -> parity_err=1.
